// File: rtl/pll_cen_gen.sv
// Multi-channel fractional clock-enable generator.
// Each channel runs a phase accumulator. Its registered carry-out is the
// clock-enable strobe, and its MSB is the ~50% duty phase signal. A
// settle/lock FSM gates every output. A single-cycle configuration
// handshake reloads all increments and restarts the channels phase-aligned.
module pll_cen_gen #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_INCR = '0
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  input  logic [NUM_CH*ACC_W-1:0] cfg_incr,
  output logic                    cfg_ready,
  output logic [NUM_CH-1:0]       cen,
  output logic [NUM_CH-1:0]       clk_ph,
  output logic                    locked
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  incr_r [NUM_CH];
  logic [ACC_W-1:0]  acc    [NUM_CH];
  logic [NUM_CH-1:0] carry_r;
  logic              accept;

  // Handshake: a configuration is taken whenever the block is out of reset.
  always_comb begin
    cfg_ready = (state != ST_RESET);
    accept    = cfg_valid & cfg_ready;
  end

  // Per-channel phase accumulators with registered carry-out.
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        incr_r[i] <= INIT_INCR[i*ACC_W +: ACC_W];
        acc[i]    <= '0;
      end
      carry_r <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        incr_r[i] <= cfg_incr[i*ACC_W +: ACC_W];
        acc[i]    <= '0;
      end
      carry_r <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        {carry_r[i], acc[i]} <= {1'b0, acc[i]} + {1'b0, incr_r[i]};
      end
    end
  end

  // Settle/lock state machine. The lock flag is registered on the same
  // edge as the transition into LOCKED.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state  <= ST_RESET;
      cnt    <= '0;
      locked <= 1'b0;
    end else if (accept) begin
      state  <= ST_SETTLE;
      cnt    <= '0;
      locked <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          state <= ST_SETTLE;
          cnt   <= '0;
        end
        ST_SETTLE: begin
          if (cnt == CNT_LAST) begin
            state  <= ST_LOCKED;
            locked <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          locked <= 1'b1;
        end
        default: begin
          state  <= ST_RESET;
          cnt    <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Output gating: only registered state reaches the outputs.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cen[i]    = carry_r[i] & locked;
      clk_ph[i] = acc[i][ACC_W-1] & locked;
    end
  end

endmodule
